pipeline_controller: RTL
========================

// Module: pipeline_controller
// PURPOSE
//  Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB): run/pause/single-step via commands,
//  load-use stall detection with ID/EX bubble insertion, and halt drain. Generates enables
//  for the PC, the IF/ID and remaining stage registers, and the ID/EX flush.
//  Sits beside the decode stage and is driven by the debug/command interface.
// PARAMETERS
//  REG_ADDR_BITS   5   register address width (rs/rt fields)
//  DRAIN_CYCLES    4   cycles the pipeline runs after HALT is fetched (ID..WB retire)
//  CNT_BITS        32  width of executed-cycle counter
// PORTS
//  clk             in   1              clock, all state on posedge
//  rst             in   1              synchronous reset, active-high
//  cmd_run         in   1              pulse: continuous run
//  cmd_step        in   1              pulse: advance exactly one cycle
//  cmd_stop        in   1              pulse: pause continuous run
//  halt_fetched    in   1              IF stage holds HALT opcode this cycle
//  id_ex_mem_read  in   1              instruction in EX is a load
//  id_ex_rt        in   REG_ADDR_BITS  load destination register in EX
//  if_id_rs        in   REG_ADDR_BITS  rs of instruction in ID
//  if_id_rt        in   REG_ADDR_BITS  rt of instruction in ID
//  pc_en           out  1              PC register write enable
//  if_id_en        out  1              IF/ID register write enable
//  if_id_flush     out  1              load NOP into IF/ID
//  id_ex_flush     out  1              load NOP (all control buses 0) into ID/EX
//  pipe_en         out  1              enable for ID/EX, EX/MEM, MEM/WB, register-bank write
//  running         out  1              state is RUN
//  halted          out  1              state is DONE
//  cycle_count     out  CNT_BITS       cycles with pipe_en=1
// BEHAVIOUR
//  States: IDLE, RUN, STEP, DRAIN, DONE. rst -> IDLE, drain_cnt=0, cycle_count=0, all outputs 0.
//  hazard = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
//  Outputs combinational from state+inputs; state/counters registered.
//  IDLE : all enables 0. cmd_run -> RUN; else cmd_step -> STEP (cmd_run wins if both).
//  RUN/STEP cycle: pipe_en=1; pc_en=if_id_en=~hazard; id_ex_flush=hazard.
//   halt_fetched (checked before hazard): pc_en=0, if_id_flush=1, drain_cnt<=DRAIN_CYCLES-1, -> DRAIN.
//   RUN: cmd_stop -> IDLE after this cycle (this cycle still executes); cmd_run/cmd_step ignored.
//   STEP: always exactly one enabled cycle, then IDLE (a stall cycle counts as the step).
//  DRAIN: pipe_en=1, pc_en=0, if_id_en=0, if_id_flush=1; drain_cnt decrements; at 0 -> DONE.
//   cmd_* ignored in DRAIN (drain not pausable).
//  DONE : all enables 0, halted=1; only rst leaves. Commands ignored.
//  cycle_count += 1 each cycle pipe_en=1; saturates at all-ones (no wrap).
//  rst mid-RUN/DRAIN: next cycle IDLE, counters 0, outputs 0; no partial drain resumes.
//  Register $0 never causes a stall; hazard ignored in IDLE/DRAIN/DONE.
// TESTING
//  rst high 2 cycles -> all outputs 0, cycle_count=0, state IDLE; cmd_step w/o run -> exactly 1 cycle pipe_en=1, cycle_count=1.
//  cmd_run, 10 cycles, cmd_stop -> pipe_en high 11 cycles incl. stop cycle, cycle_count=11, running falls.
//  RUN, id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; id_ex_rt=0 -> no stall.
//  RUN, halt_fetched pulse -> pc_en=0 from that cycle, pipe_en high 1+DRAIN_CYCLES=5 cycles total, then halted=1, cmd_run ignored.
//  cmd_run and cmd_step same cycle in IDLE -> RUN; rst during DRAIN (cnt=2) -> IDLE next cycle, halted=0, cycle_count=0.
//  Force cycle_count near max (CNT_BITS=4 build): 20 RUN cycles -> count holds 15.

Source files
------------

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//
// Purpose:
//   Sequences a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Commands start a
//   continuous run, pause it, or advance a single cycle. While executing it
//   detects load-use hazards and stalls by inserting an ID/EX bubble. When a
//   HALT is fetched it stops fetching and lets the instructions already in
//   flight retire before parking in DONE.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   cmd_run         pulse: enter continuous run
//   cmd_step        pulse: execute exactly one cycle
//   cmd_stop        pulse: pause continuous run after the current cycle
//   halt_fetched    IF stage holds a HALT opcode this cycle
//   id_ex_mem_read  instruction in EX is a load
//   id_ex_rt        destination register of that load
//   if_id_rs/rt     source registers of the instruction in ID
//   pc_en           PC write enable
//   if_id_en        IF/ID write enable
//   if_id_flush     load a NOP into IF/ID
//   id_ex_flush     load a NOP into ID/EX
//   pipe_en         enable for ID/EX, EX/MEM, MEM/WB and register-file write
//   running         controller is in continuous run
//   halted          controller has finished draining after HALT
//   cycle_count     number of cycles with pipe_en=1, saturating
// -----------------------------------------------------------------------------
module pipeline_controller #(
    parameter int REG_ADDR_BITS = 5,
    parameter int DRAIN_CYCLES  = 4,
    parameter int CNT_BITS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_run,
    input  logic                     cmd_step,
    input  logic                     cmd_stop,
    input  logic                     halt_fetched,
    input  logic                     id_ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] id_ex_rt,
    input  logic [REG_ADDR_BITS-1:0] if_id_rs,
    input  logic [REG_ADDR_BITS-1:0] if_id_rt,
    output logic                     pc_en,
    output logic                     if_id_en,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     pipe_en,
    output logic                     running,
    output logic                     halted,
    output logic [CNT_BITS-1:0]      cycle_count
);

    // Width large enough to hold DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DW-1:0]       r_drain_cnt;
    logic [DW-1:0]       w_drain_cnt_next;
    logic [CNT_BITS-1:0] r_cycle_count;

    logic w_hazard;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_pipe_en;

    // Load-use hazard: the load in EX writes a register the instruction in
    // ID reads. $0 is hard-wired to zero so it never creates a dependency.
    assign w_hazard = id_ex_mem_read
                    && (id_ex_rt != '0)
                    && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_pc_en          = 1'b0;
        w_if_id_en       = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_ex_flush    = 1'b0;
        w_pipe_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_run) begin
                    w_state_next = ST_RUN;
                end else if (cmd_step) begin
                    w_state_next = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                w_pipe_en = 1'b1;
                if (halt_fetched) begin
                    // Stop fetching; IF/ID captures a NOP in place of HALT so
                    // only the older instructions go on to retire.
                    w_if_id_en       = 1'b1;
                    w_if_id_flush    = 1'b1;
                    w_drain_cnt_next = DW'(DRAIN_CYCLES - 1);
                    w_state_next     = ST_DRAIN;
                end else begin
                    // Stall: hold PC and IF/ID, bubble into ID/EX.
                    w_pc_en       = ~w_hazard;
                    w_if_id_en    = ~w_hazard;
                    w_id_ex_flush = w_hazard;
                    if (r_state == ST_STEP || cmd_stop) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                w_pipe_en     = 1'b1;
                w_if_id_flush = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - DW'(1);
                end
            end

            ST_DONE: begin
                w_state_next = ST_DONE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_drain_cnt   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            if (w_pipe_en && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + CNT_BITS'(1);
            end
        end
    end

    assign pc_en       = w_pc_en;
    assign if_id_en    = w_if_id_en;
    assign if_id_flush = w_if_id_flush;
    assign id_ex_flush = w_id_ex_flush;
    assign pipe_en     = w_pipe_en;
    assign running     = (r_state == ST_RUN);
    assign halted      = (r_state == ST_DONE);
    assign cycle_count = r_cycle_count;

endmodule
